// File: rtl/pipe_fetch.sv
// Instruction-fetch stage and IF/ID register: owns the PC, fetches over a
// variable-latency req/ack port, parks one word across decode stalls.
module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] jra,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dpc4,
    output logic [31:0] inst
);

    logic [31:0] pc;
    logic [31:0] fbuf;
    logic        fbuf_v;
    logic [31:0] tgt;
    logic        redir_p;

    logic [31:0] pc_plus4;
    logic [31:0] npc;
    logic [31:0] word;
    logic        avail;
    logic        redirect;

    // Handshake: imem_req stays high with imem_addr frozen until a cycle with
    // imem_ack=1 (ack may coincide with the rising req); that cycle transfers
    // imem_rdata. Req drops while a word is parked in fbuf.
    assign imem_req  = resetn & ~fbuf_v;
    assign imem_addr = pc;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        avail    = fbuf_v | imem_ack;
        word     = fbuf_v ? fbuf : imem_rdata;
        redirect = wpcir && (pcsource != 2'b00);
        unique case (pcsource)
            2'b01:   npc = bpc;
            2'b10:   npc = jra;
            2'b11:   npc = jpc;
            default: npc = pc_plus4;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc      <= RESET_PC;
            fbuf    <= 32'h0;
            fbuf_v  <= 1'b0;
            tgt     <= 32'h0;
            redir_p <= 1'b0;
            dpc4    <= 32'h0;
            inst    <= 32'h0;
        end else if (wpcir) begin
            if (avail) begin
                dpc4   <= pc_plus4;
                inst   <= word;
                fbuf_v <= 1'b0;
                // A same-cycle redirect belongs to the instruction in ID, so the
                // word just delivered is its delay slot and npc follows directly.
                if (redirect) begin
                    pc <= npc;
                end else if (redir_p) begin
                    pc      <= tgt;
                    redir_p <= 1'b0;
                end else begin
                    pc <= pc_plus4;
                end
            end else begin
                dpc4 <= 32'h0;
                inst <= 32'h0;
                // Delay slot still in flight: remember where to go after it.
                if (redirect) begin
                    tgt     <= npc;
                    redir_p <= 1'b1;
                end
            end
        end else if (imem_ack && !fbuf_v) begin
            fbuf   <= imem_rdata;
            fbuf_v <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_fetch.sv
// Bench for pipe_fetch: directed scenarios plus a randomized run against an
// in-order delivery model with a variable-latency memory.
module tb_pipe_fetch;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        wpcir = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0;
    logic [31:0] jpc = 32'h0;
    logic [31:0] jra = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] dpc4;
    logic [31:0] inst;

    always #5 clock = ~clock;

    pipe_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .resetn(resetn), .wpcir(wpcir), .pcsource(pcsource),
        .bpc(bpc), .jpc(jpc), .jra(jra),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dpc4(dpc4), .inst(inst)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: next address to deliver, parked-word flag, pending target.
    logic [31:0] m_next;
    logic [31:0] m_tgt;
    bit          m_held;
    bit          m_pend;
    logic [31:0] exp_dpc4;
    logic [31:0] exp_inst;
    logic [31:0] exp_fetch;
    bit          exp_req;
    bit          obs_req;
    logic [31:0] obs_addr;

    // Memory: mem_lat wait cycles before ack, negative means random 0..3.
    int mem_lat = 0;
    int wait_left = 0;
    bit req_active = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000_0001;
    endfunction

    task automatic model_reset();
        m_next     = 32'h0;
        m_tgt      = 32'h0;
        m_held     = 1'b0;
        m_pend     = 1'b0;
        exp_dpc4   = 32'h0;
        exp_inst   = 32'h0;
        req_active = 1'b0;
        wait_left  = 0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        resetn   = 1'b0;
        wpcir    = 1'b0;
        pcsource = 2'b00;
        imem_ack = 1'b0;
        repeat (2) @(posedge clock);
        model_reset();
        #1 resetn = 1'b1;
    endtask

    // One clock: drive decode + memory at negedge, update model, land #1 after posedge.
    task automatic cycle(input bit w, input logic [1:0] ps, input logic [31:0] b,
                         input logic [31:0] r, input logic [31:0] j);
        bit ack;
        @(negedge clock);
        wpcir    = w;
        pcsource = ps;
        bpc      = b;
        jra      = r;
        jpc      = j;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        exp_req  = !m_held;
        exp_fetch = m_next;
        ack = 1'b0;
        if (imem_req) begin
            if (!req_active) begin
                req_active = 1'b1;
                wait_left  = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            end
            if (wait_left == 0) begin
                ack        = 1'b1;
                req_active = 1'b0;
            end else begin
                wait_left--;
            end
        end
        imem_ack   = ack;
        imem_rdata = ack ? mem_word(imem_addr) : $urandom;
        if (w) begin
            if (ps != 2'b00) begin
                m_pend = 1'b1;
                m_tgt  = (ps == 2'b01) ? b : (ps == 2'b10) ? r : j;
            end
            if (m_held || ack) begin
                exp_dpc4 = m_next + 32'd4;
                exp_inst = mem_word(m_next);
                m_next   = m_pend ? m_tgt : m_next + 32'd4;
                m_pend   = 1'b0;
                m_held   = 1'b0;
            end else begin
                exp_dpc4 = 32'h0;
                exp_inst = 32'h0;
            end
        end else if (ack && !m_held) begin
            m_held = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_to_0x20();
        apply_reset();
        mem_lat = 0;
        repeat (9) cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        n_vec++;
        if (inst !== mem_word(32'h20)) begin
            n_err++;
            $display("FAIL setup_id_0x20: inst=%h want=%h", inst, mem_word(32'h20));
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(posedge clock);
        #1;
        n_vec += 3;
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got=%b want=0", imem_req); end
        if (dpc4 !== 32'h0) begin n_err++; $display("FAIL reset_dpc4: got=%h want=0", dpc4); end
        if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got=%h want=0", inst); end
        imem_ack = 1'b0;
    endtask

    task automatic test_zero_wait();
        apply_reset();
        mem_lat = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
            n_vec += 4;
            if (obs_req !== 1'b1) begin n_err++; $display("FAIL zw_req[%0d]: got=%b want=1", i, obs_req); end
            if (obs_addr !== 32'(4 * i)) begin n_err++; $display("FAIL zw_addr[%0d]: got=%h want=%h", i, obs_addr, 32'(4 * i)); end
            if (inst !== mem_word(32'(4 * i))) begin n_err++; $display("FAIL zw_inst[%0d]: got=%h want=%h", i, inst, mem_word(32'(4 * i))); end
            if (dpc4 !== 32'(4 * i + 4)) begin n_err++; $display("FAIL zw_dpc4[%0d]: got=%h want=%h", i, dpc4, 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        mem_lat = 0;
        repeat (4) cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            n_vec += 3;
            if (obs_req !== (i == 0)) begin n_err++; $display("FAIL stall_req[%0d]: got=%b want=%b", i, obs_req, i == 0); end
            if (inst !== mem_word(32'hC)) begin n_err++; $display("FAIL stall_inst_hold[%0d]: got=%h want=%h", i, inst, mem_word(32'hC)); end
            if (dpc4 !== 32'h10) begin n_err++; $display("FAIL stall_dpc4_hold[%0d]: got=%h want=10", i, dpc4); end
        end
        cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        n_vec += 3;
        if (obs_req !== 1'b0) begin n_err++; $display("FAIL drain_req: got=%b want=0", obs_req); end
        if (inst !== mem_word(32'h10)) begin n_err++; $display("FAIL drain_inst: got=%h want=%h", inst, mem_word(32'h10)); end
        if (dpc4 !== 32'h14) begin n_err++; $display("FAIL drain_dpc4: got=%h want=14", dpc4); end
        cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        n_vec += 2;
        if (obs_req !== 1'b1) begin n_err++; $display("FAIL refetch_req: got=%b want=1", obs_req); end
        if (obs_addr !== 32'h14) begin n_err++; $display("FAIL refetch_addr: got=%h want=14", obs_addr); end
    endtask

    task automatic test_redirects();
        logic [31:0] tg [3];
        tg[0] = 32'h100;
        tg[1] = 32'h40;
        tg[2] = 32'h80;
        for (int k = 0; k < 3; k++) begin
            run_to_0x20();
            cycle(1'b1, 2'(k + 1), tg[0], tg[1], tg[2]);
            n_vec += 2;
            if (inst !== mem_word(32'h24)) begin n_err++; $display("FAIL redir%0d_slot_inst: got=%h want=%h", k + 1, inst, mem_word(32'h24)); end
            if (dpc4 !== 32'h28) begin n_err++; $display("FAIL redir%0d_slot_dpc4: got=%h want=28", k + 1, dpc4); end
            cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
            n_vec += 3;
            if (obs_addr !== tg[k]) begin n_err++; $display("FAIL redir%0d_addr: got=%h want=%h", k + 1, obs_addr, tg[k]); end
            if (inst !== mem_word(tg[k])) begin n_err++; $display("FAIL redir%0d_tgt_inst: got=%h want=%h", k + 1, inst, mem_word(tg[k])); end
            if (dpc4 !== tg[k] + 32'd4) begin n_err++; $display("FAIL redir%0d_tgt_dpc4: got=%h want=%h", k + 1, dpc4, tg[k] + 32'd4); end
        end
    endtask

    task automatic test_branch_latency();
        run_to_0x20();
        mem_lat = 2;
        cycle(1'b1, 2'b01, 32'h100, 32'h0, 32'h0);
        n_vec++;
        if (inst !== 32'h0) begin n_err++; $display("FAIL lat_bubble0: got=%h want=0", inst); end
        cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        n_vec++;
        if (inst !== 32'h0) begin n_err++; $display("FAIL lat_bubble1: got=%h want=0", inst); end
        cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        n_vec += 2;
        if (inst !== mem_word(32'h24)) begin n_err++; $display("FAIL lat_slot_inst: got=%h want=%h", inst, mem_word(32'h24)); end
        if (dpc4 !== 32'h28) begin n_err++; $display("FAIL lat_slot_dpc4: got=%h want=28", dpc4); end
        cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        n_vec += 2;
        if (obs_req !== 1'b1) begin n_err++; $display("FAIL lat_tgt_req: got=%b want=1", obs_req); end
        if (obs_addr !== 32'h100) begin n_err++; $display("FAIL lat_tgt_addr: got=%h want=100", obs_addr); end
    endtask

    task automatic test_wrap();
        run_to_0x20();
        cycle(1'b1, 2'b11, 32'h0, 32'h0, 32'hFFFF_FFFC);
        cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        n_vec += 2;
        if (inst !== mem_word(32'hFFFF_FFFC)) begin n_err++; $display("FAIL wrap_inst: got=%h want=%h", inst, mem_word(32'hFFFF_FFFC)); end
        if (dpc4 !== 32'h0) begin n_err++; $display("FAIL wrap_dpc4: got=%h want=0", dpc4); end
        cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        n_vec += 2;
        if (inst !== mem_word(32'h0)) begin n_err++; $display("FAIL wrap_next_inst: got=%h want=%h", inst, mem_word(32'h0)); end
        if (dpc4 !== 32'h4) begin n_err++; $display("FAIL wrap_next_dpc4: got=%h want=4", dpc4); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        mem_lat = 0;
        repeat (4) cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        mem_lat = 3;
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        n_vec += 3;
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL midrst_req: got=%b want=0", imem_req); end
        if (inst !== 32'h0) begin n_err++; $display("FAIL midrst_inst: got=%h want=0", inst); end
        if (dpc4 !== 32'h0) begin n_err++; $display("FAIL midrst_dpc4: got=%h want=0", dpc4); end
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0BAD;
        wpcir      = 1'b1;
        repeat (2) @(posedge clock);
        model_reset();
        #1 resetn = 1'b1;
        imem_ack = 1'b0;
        mem_lat  = 0;
        cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        n_vec += 4;
        if (obs_req !== 1'b1) begin n_err++; $display("FAIL restart_req: got=%b want=1", obs_req); end
        if (obs_addr !== 32'h0) begin n_err++; $display("FAIL restart_addr: got=%h want=0", obs_addr); end
        if (inst !== mem_word(32'h0)) begin n_err++; $display("FAIL restart_inst: got=%h want=%h", inst, mem_word(32'h0)); end
        if (dpc4 !== 32'h4) begin n_err++; $display("FAIL restart_dpc4: got=%h want=4", dpc4); end
    endtask

    task automatic test_random();
        bit w;
        logic [1:0] ps;
        logic [31:0] t [3];
        apply_reset();
        mem_lat = -1;
        for (int c = 0; c < 2000; c++) begin
            w = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < 3; k++) begin
                t[k] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            end
            if (w) ps = (!m_pend && $urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            else   ps = 2'($urandom_range(0, 3));
            cycle(w, ps, t[0], t[1], t[2]);
            n_vec += 3;
            if (obs_req !== exp_req) begin n_err++; $display("FAIL rnd_req[%0d]: got=%b want=%b", c, obs_req, exp_req); end
            if (inst !== exp_inst) begin n_err++; $display("FAIL rnd_inst[%0d]: got=%h want=%h", c, inst, exp_inst); end
            if (dpc4 !== exp_dpc4) begin n_err++; $display("FAIL rnd_dpc4[%0d]: got=%h want=%h", c, dpc4, exp_dpc4); end
            if (obs_req && exp_req) begin
                n_vec++;
                if (obs_addr !== exp_fetch) begin n_err++; $display("FAIL rnd_addr[%0d]: got=%h want=%h", c, obs_addr, exp_fetch); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirects();
        test_branch_latency();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
